// File: rtl/digit_scanner_pkg.sv
// digit_scanner_pkg: types and constants shared by the multiplexed display
// scanner. Holds the per-slot FSM state type and the inactive (all-ones)
// drive levels for the active-low anode and segment outputs.
package digit_scanner_pkg;

  // Each digit slot opens with a dead-time phase, then shows the digit.
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Anodes and segments are active-low, so "off" is a one on every bit.
  localparam logic ANODE_OFF = 1'b1;
  localparam logic SEG_OFF   = 1'b1;

endpackage

// File: rtl/slot_timer.sv
// slot_timer: prescaler that divides the system clock into digit slots.
// It counts 0..REFRESH_DIV-1 and wraps.
//
// Ports:
//   clk        system clock, rising edge
//   rstN       synchronous active-low reset (prescaler back to 0)
//   slot_end   high in the last cycle of a slot (the wrap cycle)
//   show_next  high in the last dead-time cycle; the show phase starts
//              on the following edge
module slot_timer #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rstN,
  output logic slot_end,
  output logic show_next
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt;

  assign slot_end  = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign show_next = (cnt == CNT_W'(BLANK_CYCLES - 1));

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/digit_scanner.sv
// digit_scanner: time-multiplexed driver for a NUM_DIGITS-digit LED display.
// Each digit gets one slot of REFRESH_DIV cycles: BLANK_CYCLES of dead time
// (anti-ghosting) followed by the show phase. A shadow frame decouples the
// display from segData; it is reloaded only at a frame boundary.
//
// Optional feature: define DIGIT_SCANNER_DIMMING_EN to add a 4-bit brightness
// input and a free-running 4-bit PWM counter; during the show phase the anode
// is then only driven while the PWM count is <= brightness.
//
// Ports:
//   clk        system clock, rising edge
//   rstN       synchronous active-low reset
//   segData    frame data, digit i in [i*SEG_W +: SEG_W], active-low segments
//   digitEn    per-digit enable (0 blanks that digit), captured with segData
//   load       level request to capture segData/digitEn, held until loadAck
//   brightness (dimming build only) 0 = 1/16 duty .. 15 = full on
//   loadAck    one-cycle pulse: the shadow frame is captured at the end of
//              this cycle
//   anode      active-low digit selects, at most one bit low
//   ledx       active-low segment drive for the selected digit
//   digitIdx   index of the current slot
//   frameDone  one-cycle pulse in the last cycle of the last digit's slot
module digit_scanner
  import digit_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SEG_W        = 8,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic [NUM_DIGITS*SEG_W-1:0]   segData,
  input  logic [NUM_DIGITS-1:0]         digitEn,
  input  logic                          load,
`ifdef DIGIT_SCANNER_DIMMING_EN
  input  logic [3:0]                    brightness,
`endif
  output logic                          loadAck,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [SEG_W-1:0]              ledx,
  output logic [$clog2(NUM_DIGITS)-1:0] digitIdx,
  output logic                          frameDone
);

  localparam int                IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic                               slot_end;
  logic                               show_next;
  scan_state_t                        state;
  scan_state_t                        state_next;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]   shadow_seg;
  logic [NUM_DIGITS-1:0]              shadow_en;
  logic                               capture;
  logic                               digit_on;
  logic [NUM_DIGITS-1:0]              anode_next;
  logic [SEG_W-1:0]                   ledx_next;

  slot_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clk       (clk),
    .rstN      (rstN),
    .slot_end  (slot_end),
    .show_next (show_next)
  );

  // The frame ends in the wrap cycle of the last digit. A pending load is
  // captured on that same edge, so the new frame starts with digit 0.
  assign frameDone = slot_end && (digitIdx == LAST_IDX);
  assign capture   = frameDone && load;
  assign loadAck   = capture;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      digitIdx <= '0;
    end else if (slot_end) begin
      digitIdx <= (digitIdx == LAST_IDX) ? '0 : digitIdx + 1'b1;
    end
  end

  // Slot FSM: state register plus next-state logic.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state <= BLANK;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BLANK:   if (show_next) state_next = SHOW;
      SHOW:    if (slot_end)  state_next = BLANK;
      default: state_next = BLANK;
    endcase
  end

  // NOTE: the shadow frame is reset on purpose (segments off, digits
  // disabled) so the display stays dark until the first load is accepted.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      shadow_seg <= {(NUM_DIGITS*SEG_W){SEG_OFF}};
      shadow_en  <= '0;
    end else if (capture) begin
      shadow_seg <= segData;
      shadow_en  <= digitEn;
    end
  end

`ifdef DIGIT_SCANNER_DIMMING_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign digit_on = (state == SHOW) && shadow_en[digitIdx] && (pwm_cnt <= brightness);
`else
  assign digit_on = (state == SHOW) && shadow_en[digitIdx];
`endif

  // NOTE: every output of this block gets a default before the condition,
  // otherwise the tool would infer latches to hold the old value.
  always_comb begin
    anode_next = {NUM_DIGITS{ANODE_OFF}};
    ledx_next  = {SEG_W{SEG_OFF}};
    if (digit_on) begin
      anode_next[digitIdx] = 1'b0;
      ledx_next            = shadow_seg[digitIdx];
    end
  end

  // Outputs are registered, so each state change shows up one edge later,
  // on both the BLANK->SHOW and SHOW->BLANK transitions alike.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      anode <= {NUM_DIGITS{ANODE_OFF}};
      ledx  <= {SEG_W{SEG_OFF}};
    end else begin
      anode <= anode_next;
      ledx  <= ledx_next;
    end
  end

endmodule

// File: tb/tb_digit_scanner.sv
// tb_digit_scanner: self-checking bench for digit_scanner with
// NUM_DIGITS=4, SEG_W=8, REFRESH_DIV=8, BLANK_CYCLES=2.
// A cycle-level reference model pushes the expected outputs of each cycle
// into a scoreboard queue when the stimulus for that cycle is driven; the
// entry is popped and compared when the DUT outputs are sampled mid-cycle.
module tb_digit_scanner;

  localparam int ND    = 4;
  localparam int SW    = 8;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * RD;

  logic          clk = 1'b0;
  logic          rstN;
  logic [31:0]   segData;
  logic [3:0]    digitEn;
  logic          load;
  logic          loadAck;
  logic [3:0]    anode;
  logic [7:0]    ledx;
  logic [1:0]    digitIdx;
  logic          frameDone;
`ifdef DIGIT_SCANNER_DIMMING_EN
  logic [3:0]    brightness;
`endif

  typedef struct packed {
    logic [3:0] anode;
    logic [7:0] ledx;
    logic [1:0] idx;
    logic       fd;
    logic       ack;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;

  // Reference model state.
  int          n;            // cycles since reset release
  bit          model_valid;
  logic [31:0] m_seg;        // shadow frame as the DUT should hold it
  logic [3:0]  m_en;
  logic [3:0]  m_anode;      // registered outputs expected this cycle
  logic [7:0]  m_ledx;
  logic [3:0]  m_pwm;
  int          ack_seen;

  digit_scanner #(
    .NUM_DIGITS   (ND),
    .SEG_W        (SW),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk       (clk),
    .rstN      (rstN),
    .segData   (segData),
    .digitEn   (digitEn),
    .load      (load),
`ifdef DIGIT_SCANNER_DIMMING_EN
    .brightness(brightness),
`endif
    .loadAck   (loadAck),
    .anode     (anode),
    .ledx      (ledx),
    .digitIdx  (digitIdx),
    .frameDone (frameDone)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  // One clock cycle: push expectation, sample and compare at the falling
  // edge, then advance the model across the next rising edge.
  task automatic step();
    exp_t e;
    exp_t got;
    int   ph;
    int   dig;
    logic pwm_ok;
    logic show;
    ph    = n % RD;
    dig   = (n / RD) % ND;
    e.anode = m_anode;
    e.ledx  = m_ledx;
    e.idx   = 2'(dig);
    e.fd    = (n % FRAME == FRAME - 1);
    e.ack   = e.fd && load;
    if (model_valid) sb.push_back(e);

    @(negedge clk);
    if (loadAck === 1'b1) ack_seen++;
    if (model_valid) begin
      got = sb.pop_front();
      check("anode",     {28'd0, anode},     {28'd0, got.anode});
      check("ledx",      {24'd0, ledx},      {24'd0, got.ledx});
      check("digitIdx",  {30'd0, digitIdx},  {30'd0, got.idx});
      check("frameDone", {31'd0, frameDone}, {31'd0, got.fd});
      check("loadAck",   {31'd0, loadAck},   {31'd0, got.ack});
    end

`ifdef DIGIT_SCANNER_DIMMING_EN
    pwm_ok = (m_pwm <= brightness);
`else
    pwm_ok = 1'b1;
`endif
    // The show phase covers prescaler values BC..RD-1; the registered
    // outputs reflect it one edge later.
    show = (ph >= BC) && m_en[dig] && pwm_ok;

    if (rstN === 1'b0) begin
      n           = 0;
      m_seg       = 32'hFFFF_FFFF;
      m_en        = 4'h0;
      m_anode     = 4'hF;
      m_ledx      = 8'hFF;
      m_pwm       = 4'h0;
      model_valid = 1'b1;
    end else begin
      if (show) begin
        m_anode      = 4'hF;
        m_anode[dig] = 1'b0;
        m_ledx       = m_seg[dig*SW +: SW];
      end else begin
        m_anode = 4'hF;
        m_ledx  = 8'hFF;
      end
      if (e.fd && load) begin
        m_seg = segData;
        m_en  = digitEn;
      end
      n++;
      m_pwm = m_pwm + 4'd1;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Hold load until the DUT acknowledges, bounded by a cycle budget.
  task automatic wait_ack(input int limit);
    int start;
    int k;
    start = ack_seen;
    k     = 0;
    while (ack_seen == start && k < limit) begin
      step();
      k++;
    end
    check("loadAck_within_budget", {31'd0, ack_seen != start}, 32'd1);
  endtask

  initial begin
    int acks_before;
    rstN        = 1'b0;
    load        = 1'b0;
    segData     = 32'hFFFF_FFFF;
    digitEn     = 4'h0;
`ifdef DIGIT_SCANNER_DIMMING_EN
    brightness  = 4'd15;
`endif
    n           = 0;
    model_valid = 1'b0;
    m_seg       = 32'hFFFF_FFFF;
    m_en        = 4'h0;
    m_anode     = 4'hF;
    m_ledx      = 8'hFF;
    m_pwm       = 4'h0;
    ack_seen    = 0;

    // Reset: first cycle only establishes the model, second checks reset values.
    step();
    step();

    // Basic frame: load 0x11223344, all digits enabled.
    rstN    = 1'b1;
    segData = 32'h1122_3344;
    digitEn = 4'hF;
    load    = 1'b1;
    wait_ack(2 * FRAME);
    load    = 1'b0;
    run(2 * FRAME);

    // Digit 2 disabled: its slot stays dark, frame rate unchanged.
    digitEn = 4'b1011;
    load    = 1'b1;
    wait_ack(2 * FRAME);
    load    = 1'b0;
    run(2 * FRAME);

    // New data without load has no effect; a short load pulse mid-frame
    // is not captured.
    segData = 32'hAABB_CCDD;
    digitEn = 4'hF;
    run(FRAME);
    acks_before = ack_seen;
    run(5);
    load = 1'b1;
    run(3);
    load = 1'b0;
    run(FRAME - 8);
    check("no_ack_for_short_load", ack_seen - acks_before, 32'd0);

    // Continuous load: exactly one capture per frame.
    acks_before = ack_seen;
    load = 1'b1;
    run(2 * FRAME);
    load = 1'b0;
    check("one_ack_per_frame", ack_seen - acks_before, 32'd2);
    run(FRAME);

`ifdef DIGIT_SCANNER_DIMMING_EN
    // Dimmed: anode active only while the PWM count is <= 3.
    brightness = 4'd3;
    run(2 * FRAME);
    brightness = 4'd15;
    run(FRAME);
`endif

    // Reset during the show phase of digit 2.
    while ((n % FRAME) != 2 * RD + 4) step();
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    step();
    // Shadow frame was cleared: display dark until a new load.
    run(FRAME);
    segData = 32'h0F1E_2D3C;
    digitEn = 4'b0101;
    load    = 1'b1;
    wait_ack(2 * FRAME);
    load    = 1'b0;
    run(FRAME + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
